// File: rtl/pwm_pkg.sv
// Shared constants, channel-mode type and helpers for the 16-channel PWM output stage.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int NUM_CH = 16;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_STATIC = 2'd1,
    CH_PWM    = 2'd2
  } ch_mode_t;

  // Divider width: a 1-bit counter is kept even for CLK_DIV=1 so the logic stays uniform.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Output enable dominates the PWM select.
  function automatic ch_mode_t ch_mode(input logic en_out, input logic en_pwm);
    if (!en_out) return CH_OFF;
    if (!en_pwm) return CH_STATIC;
    return CH_PWM;
  endfunction

  function automatic logic ch_level(input ch_mode_t mode, input logic pwm_high);
    case (mode)
      CH_STATIC: return 1'b1;
      CH_PWM:    return pwm_high;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high for one clock out of every CLK_DIV clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = presc_width(CLK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // With CLK_DIV=1, P_LAST is 0 and p_q never leaves 0, so tick is constantly high.
  assign tick = (p_q == P_LAST);

  always_comb begin
    p_d = p_q + PW'(1);
    if (tick) p_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: off / static high / shared 8-bit PWM per channel,
// with the duty cycle shadowed to period boundaries for glitch-free waveforms.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              pwm_period_start
);

  localparam logic [PWM_CNT_W-1:0] CNT_LAST = '1;

  logic                 tick;
  logic                 wrap;
  logic                 pwm_high;
  logic [NUM_CH-1:0]    en_out;
  logic [NUM_CH-1:0]    en_pwm;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [NUM_CH-1:0]    out_q, out_d;
  logic                 period_start_q, period_start_d;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Full-scale duty is special-cased so 0xFF has no one-step low gap.
  assign wrap     = tick && (cnt_q == CNT_LAST);
  assign pwm_high = (duty_shadow_q == DUTY_FULL) || (cnt_q < duty_shadow_q);

  always_comb begin
    cnt_d          = cnt_q;
    duty_shadow_d  = duty_shadow_q;
    period_start_d = wrap;
    if (tick) cnt_d = cnt_q + PWM_CNT_W'(1);
    if (wrap) duty_shadow_d = pwm_duty_cycle;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign out_d[gi] = ch_level(ch_mode(en_out[gi], en_pwm[gi]), pwm_high);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out              = out_q;
  assign pwm_period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench: stimulus queues expected snapshots and per-period statistics;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pwm_peripheral;

  localparam int DIV = 13;
  localparam int PER = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
  logic [15:0] out;
  logic        pstart;

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .pwm_period_start(pstart)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] o;
    logic        ps;
    string       name;
  } snap_t;

  typedef struct {
    int    len;
    int    hi0;
    int    hi1;
    int    ones;
    int    odd_bad;
    string name;
  } win_t;

  snap_t sq[$];
  win_t  wq[$];
  snap_t s_cur;
  win_t  w_cur;

  int   cyc = 0;
  int   rel = 0;
  logic rst_edge = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst_n;
    rel      <= rst_n ? rel + 1 : 0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- monitor ----------------
  int         w_len = 0, w_hi0 = 0, w_hi1 = 0, w_ones = 0, w_odd = 0;
  logic       prev_ps = 1'b0;
  logic [7:0] odd_v;

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s_cur = sq.pop_front();
      if (s_cur.cyc != cyc) begin
        chk({s_cur.name, "_late"}, cyc, s_cur.cyc);
      end else begin
        $display("snap %s cyc=%0d out=%h ps=%b (exp out=%h ps=%b)",
                 s_cur.name, cyc, out, pstart, s_cur.o, s_cur.ps);
        chk({s_cur.name, "_out"}, int'(out), int'(s_cur.o));
        chk({s_cur.name, "_pstart"}, int'(pstart), int'(s_cur.ps));
      end
    end

    // Windows are bounded by the clock after each period-start pulse, which is
    // where the registered out first reflects the new period.
    if (!rst_edge) begin
      w_len = 0; w_hi0 = 0; w_hi1 = 0; w_ones = 0; w_odd = 0;
      prev_ps = 1'b0;
    end else begin
      if (prev_ps) begin
        if (wq.size() == 0) begin
          chk("unexpected_period", 1, 0);
        end else begin
          w_cur = wq.pop_front();
          $display("win %s len=%0d hi0=%0d hi1=%0d ones=%0d odd_bad=%0d",
                   w_cur.name, w_len, w_hi0, w_hi1, w_ones, w_odd);
          chk({w_cur.name, "_len"}, w_len, w_cur.len);
          chk({w_cur.name, "_hi0"}, w_hi0, w_cur.hi0);
          chk({w_cur.name, "_hi1"}, w_hi1, w_cur.hi1);
          chk({w_cur.name, "_ones"}, w_ones, w_cur.ones);
          chk({w_cur.name, "_phase"}, w_odd, w_cur.odd_bad);
        end
        w_len = 0; w_hi0 = 0; w_hi1 = 0; w_ones = 0; w_odd = 0;
      end
      w_len++;
      if (out[0]) w_hi0++;
      if (out[1]) w_hi1++;
      w_ones += $countones(out);
      for (int k = 0; k < 8; k++) odd_v[k] = out[2*k+1];
      if (!(odd_v == 8'h00 || odd_v == 8'hFF)) w_odd++;
      prev_ps = pstart;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_s(input logic [15:0] o, input logic ps, input string nm);
    snap_t s;
    s.cyc = cyc + 1; s.o = o; s.ps = ps; s.name = nm;
    sq.push_back(s);
  endtask

  task automatic push_w(input int hi0, input int hi1, input int ones, input string nm);
    win_t w;
    w.len = PER; w.hi0 = hi0; w.hi1 = hi1; w.ones = ones; w.odd_bad = 0; w.name = nm;
    wq.push_back(w);
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    eo_lo = eo[7:0]; eo_hi = eo[15:8];
    ep_lo = ep[7:0]; ep_hi = ep[15:8];
    duty  = d;
  endtask

  task automatic goto_rel(input int t);
    int g = 0;
    while (rel < t && g < 20 * PER) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (wq.size() > 0 && t < 8 * PER) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_periods_seen"}, wq.size(), 0);
    wq.delete();
  endtask

  task automatic start_seg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d,
                           input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    set_cfg(eo, ep, d);
    push_s(16'h0000, 1'b0, {nm, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Static outputs and reset behaviour
    set_cfg(16'h0000, 16'h0000, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    set_cfg(16'hFFFF, 16'h0000, 8'h00);
    push_s(16'h0000, 1'b0, "a_rst_no_glitch");
    @(negedge clk); rst_n = 1'b1;
    push_s(16'hFFFF, 1'b0, "a_static_all");
    @(negedge clk); set_cfg(16'h00F0, 16'h0000, 8'h00);
    push_s(16'h00F0, 1'b0, "a_static_00F0");
    @(negedge clk); set_cfg(16'h00F0, 16'h00F0, 8'h80);
    push_s(16'h0000, 1'b0, "a_pwm_first_period_low");
    @(negedge clk); set_cfg(16'h0000, 16'hFFFF, 8'hFF);
    push_s(16'h0000, 1'b0, "a_out_disabled");
    @(negedge clk);

    // 50 % duty, then reset in the middle of a high phase
    start_seg(16'h0001, 16'h0001, 8'h80, "b");
    push_w(0, 0, 0, "b_w1");
    push_w(1664, 0, 1664, "b_w2");
    push_w(1664, 0, 1664, "b_w3");
    goto_rel(PER - 1);        push_s(16'h0000, 1'b1, "b_first_pstart");
    goto_rel(PER);            push_s(16'h0001, 1'b0, "b_first_high");
    goto_rel(PER + 1663);     push_s(16'h0001, 1'b0, "b_last_high");
    goto_rel(PER + 1664);     push_s(16'h0000, 1'b0, "b_first_low");
    drain("b");
    goto_rel(3 * PER + 99);   push_s(16'h0001, 1'b0, "f_high_before_rst");
    @(negedge clk); rst_n = 1'b0;
    push_s(16'h0000, 1'b0, "f_rst_mid_high");
    @(negedge clk); rst_n = 1'b1;
    push_s(16'h0000, 1'b0, "f_restart_low");
    push_w(0, 0, 0, "f_w1");
    push_w(1664, 0, 1664, "f_w2");
    goto_rel(PER - 1);        push_s(16'h0000, 1'b1, "f_pstart_after_restart");
    drain("f");

    // Duty extremes: 0x00 for three periods, then 0xFF
    start_seg(16'h0001, 16'h0001, 8'h00, "c");
    push_w(0, 0, 0, "c_w1");
    push_w(0, 0, 0, "c_w2");
    push_w(0, 0, 0, "c_w3");
    push_w(PER, 0, PER, "c_w4_full");
    goto_rel(2 * PER + 500);  duty = 8'hFF;
    drain("c");

    // Shadow timing: mid-period change, wrap-tick write, one-clock-late write
    start_seg(16'h0001, 16'h0001, 8'h40, "d");
    push_w(0, 0, 0, "d_w1");
    push_w(832, 0, 832, "d_w2");
    push_w(2496, 0, 2496, "d_w3");
    push_w(208, 0, 208, "d_w4_wrap_write");
    push_w(208, 0, 208, "d_w5_late_write");
    push_w(104, 0, 104, "d_w6");
    goto_rel(PER + 1000);     duty = 8'hC0;
    goto_rel(3 * PER - 1);    duty = 8'h10;
    goto_rel(4 * PER);        duty = 8'h08;
    drain("d");

    // Mixed channels: even static high, odd PWM in phase
    start_seg(16'hFFFF, 16'hAAAA, 8'h20, "e");
    push_w(PER, 0, 8 * PER, "e_w1");
    push_w(PER, 416, 8 * PER + 8 * 416, "e_w2");
    drain("e");

    repeat (2) @(negedge clk);
    chk("snapshots_consumed", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output stage driven by the SPI register file. Consumes the five configuration bytes written over SPI (output enables, PWM enables, duty cycle) and drives 16 chip outputs. Each output is forced low, held static high, or toggled by a shared 8-bit PWM generator. Duty-cycle changes are shadowed to period boundaries so that every output waveform is glitch-free.

## Interface
Parameters:
- CLK_DIV, 13: prescaler ratio; the PWM counter advances once every CLK_DIV clocks. Legal range is 1..65535. At 10 MHz the default gives 256×13 = 3328 clocks per period, about 3.0 kHz.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- en_reg_out_7_0  in  8  output enable for out[7:0]
- en_reg_out_15_8  in  8  output enable for out[15:8]
- en_reg_pwm_7_0  in  8  PWM mode select for out[7:0]
- en_reg_pwm_15_8  in  8  PWM mode select for out[15:8]
- pwm_duty_cycle  in  8  shared duty; 0x00 = 0 %, 0xFF = 100 %
- out  out  16  registered channel outputs
- pwm_period_start  out  1  one-cycle pulse, high during the first clock of each period (cnt==0)

## Operation
- All inputs are synchronous to clk. They are treated as quasi-static and need no extra synchroniser.
- Build en_out[15:0] = {en_reg_out_15_8, en_reg_out_7_0}. Build en_pwm[15:0] the same way from the PWM enable bytes.
- Per channel i:
  - en_out[i]=0 → out[i]=0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → out[i]=1 (static high).
  - en_out[i]=1, en_pwm[i]=1 → out[i]=pwm_high.
- pwm_high = (duty_shadow==8'hFF) | (cnt < duty_shadow), compared as unsigned 8-bit.
  - duty 0x00 gives constant low.
  - duty 0xFF gives constant high with no one-step gap.
  - Otherwise the output is high for duty×CLK_DIV clocks per period.
- Prescaler p, width clog2(CLK_DIV) with a minimum of 1 bit. tick = (p==CLK_DIV-1). On tick, p←0; otherwise p←p+1. When CLK_DIV=1, tick is constantly 1.
- Counter cnt, 8 bits. On tick, cnt←cnt+1, wrapping 255→0.
- Shadow load: on the tick where cnt==255, duty_shadow←pwm_duty_cycle. At no other time is it loaded.
- Reset values:
  - p=0, cnt=0, duty_shadow=0.
  - out=16'h0000, pwm_period_start=0.
- The first period after reset uses duty_shadow=0, so PWM channels are low until the first wrap. This is intended behaviour.

## Timing
- out is registered: out(t+1) = f(en_out(t), en_pwm(t), cnt(t), duty_shadow(t)).
- Enable changes appear on out exactly 1 clock later, with no period alignment.
- Duty changes take effect at the first clock of the next period: cnt==0 with the new shadow, then visible on out one clock later. A write in the final clock of a period (the wrap tick) is captured in the same cycle.
- pwm_period_start is registered. It goes high in the cycle in which cnt first equals 0 after a wrap. It is not asserted at reset release.
- Simultaneous duty write and wrap tick: the new value is loaded.
- Reset asserted mid-period: on the next clk edge all state and outputs return to reset values. Outputs must not glitch high during reset.
- Period = 256×CLK_DIV clocks, exact and jitter-free.

## Structure
- Shared package pwm_pkg holds:
  - PWM_CNT_W = 8
  - DUTY_FULL = 8'hFF
  - CLK_DIV_DEFAULT = 13
  - NUM_CH = 16
- One sub-module, pwm_prescaler (parameter CLK_DIV; ports clk, rst_n, tick). It holds the divider counter. Counter, shadow and output logic stay in pwm_peripheral.

## Test plan
- Reset then static: en_out=16'hFFFF, en_pwm=0 → out=16'hFFFF one clock after the inputs are applied. Then en_out=16'h00F0 → out=16'h00F0 the next clock.
- 50 % PWM: en_out=en_pwm=16'h0001, duty=0x80, CLK_DIV=13.
  - out[0] low for the first 3328 clocks after reset.
  - Then high 1664 / low 1664 per period.
  - pwm_period_start asserts every 3328 clocks.
- Duty extremes: duty=0x00 → out[0] never high over 3 periods. duty=0xFF → out[0] constantly high from the first post-wrap period.
- Shadow timing: change duty 0x40→0xC0 mid-period → the current period keeps 832 high clocks, and the next period has 2496 high clocks. A write exactly on the wrap tick applies in the following period.
- Mixed channels: en_out=16'hFFFF, en_pwm=16'hAAAA, duty=0x20 → even bits constant 1, odd bits high 416 clocks per period, all in phase.
- Reset mid-high-phase: assert rst_n=0 while out[0]=1 → out=0 and pwm_period_start=0 on the next edge. After release the sequence restarts from cnt=0 with duty_shadow=0.
